// File: rtl/console_pkg.sv
// Shared text-console definitions: geometry defaults, control codes, FSM and cursor command types.
package console_pkg;

  localparam int unsigned DEF_COLS   = 80;
  localparam int unsigned DEF_ROWS   = 30;
  localparam int unsigned DEF_ADDR_W = 14;
  localparam int unsigned ROW_W      = 5;
  localparam int unsigned COL_W      = 7;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam logic [7:0] CH_BS      = 8'h08;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_FF      = 8'h0C;
  localparam logic [7:0] CH_CR      = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR
  } state_t;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADVANCE,
    CUR_NEWLINE,
    CUR_CR,
    CUR_BS,
    CUR_HOME
  } cur_cmd_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Text cursor: row, column and line base address (row*COLS kept incrementally, no multiplier).
module console_cursor
  import console_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  cur_cmd_t          i_cmd,
  output logic [ROW_W-1:0]  o_row,
  output logic [COL_W-1:0]  o_col,
  output logic [ADDR_W-1:0] o_line_base
);

  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_line_base;
  logic              w_col_last;
  logic              w_row_last;

  assign w_col_last = (r_col == COL_W'(COLS - 1));
  assign w_row_last = (r_row == ROW_W'(ROWS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_line_base <= '0;
    end else begin
      case (i_cmd)
        CUR_ADVANCE, CUR_NEWLINE: begin
          if ((i_cmd == CUR_ADVANCE) && !w_col_last) begin
            r_col <= r_col + COL_W'(1);
          end else begin
            // Line step; bottom row wraps to the top, there is no scrolling.
            r_col <= '0;
            if (w_row_last) begin
              r_row       <= '0;
              r_line_base <= '0;
            end else begin
              r_row       <= r_row + ROW_W'(1);
              r_line_base <= r_line_base + ADDR_W'(COLS);
            end
          end
        end
        CUR_CR: r_col <= '0;
        CUR_BS: begin
          if (r_col != '0) r_col <= r_col - COL_W'(1);
        end
        CUR_HOME: begin
          r_row       <= '0;
          r_col       <= '0;
          r_line_base <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_row       = r_row;
  assign o_col       = r_col;
  assign o_line_base = r_line_base;

endmodule

// File: rtl/text_console_writer.sv
// Character stream to tile RAM port-A writer with cursor and control-code handling.
// Optional build macro CONSOLE_CLEAR_ON_RESET_EN: reset starts a full-buffer clear with colour 0.
module text_console_writer
  import console_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter logic [7:0]  BLANK  = BLANK_CHAR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic [7:0]        char_data,
  input  logic [7:0]        char_color,
  output logic              we_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic [15:0]       dout_a,
  output logic [4:0]        cursor_row,
  output logic [6:0]        cursor_col,
  output logic              busy
);

  localparam int unsigned TOTAL = COLS * ROWS;

  state_t            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_dout;

  cur_cmd_t          w_cmd;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [ADDR_W-1:0] w_line_base;
  logic              w_accept;
  logic              w_clear_last;

  assign w_accept     = char_valid && (r_state == ST_IDLE);
  assign w_clear_last = (r_addr == ADDR_W'(TOTAL - 1));

  // Cursor command: control codes act at the accepting edge, printables at the end of WRITE.
  always_comb begin
    w_cmd = CUR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (char_valid) begin
          case (char_data)
            CH_LF:   w_cmd = CUR_NEWLINE;
            CH_CR:   w_cmd = CUR_CR;
            CH_BS:   w_cmd = CUR_BS;
            default: w_cmd = CUR_NONE;
          endcase
        end
      end
      ST_WRITE: w_cmd = CUR_ADVANCE;
      ST_CLEAR: if (w_clear_last) w_cmd = CUR_HOME;
      default:  w_cmd = CUR_NONE;
    endcase
  end

  console_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk         (clk),
    .reset       (reset),
    .i_cmd       (w_cmd),
    .o_row       (w_row),
    .o_col       (w_col),
    .o_line_base (w_line_base)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef CONSOLE_CLEAR_ON_RESET_EN
      r_state <= ST_CLEAR;
      r_we    <= 1'b1;
      r_addr  <= '0;
      r_dout  <= {8'h00, BLANK};
`else
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_dout  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_we <= 1'b0;
          if (w_accept) begin
            if (is_printable(char_data)) begin
              r_addr  <= w_line_base + ADDR_W'(w_col);
              r_dout  <= {char_color, char_data};
              r_we    <= 1'b1;
              r_state <= ST_WRITE;
            end else if (char_data == CH_FF) begin
              r_addr  <= '0;
              r_dout  <= {char_color, BLANK};
              r_we    <= 1'b1;
              r_state <= ST_CLEAR;
            end
          end
        end
        ST_WRITE: begin
          r_we    <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_CLEAR: begin
          // Data is constant for the whole sweep; only the address moves.
          if (w_clear_last) begin
            r_we    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        default: begin
          r_we    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign char_ready = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_CLEAR);
  assign we_a       = r_we;
  assign addr_a     = r_addr;
  assign dout_a     = r_dout;
  assign cursor_row = w_row;
  assign cursor_col = w_col;

endmodule
